muldiv_ctrl: RTL and testbench

- Execute-stage sequencer that owns the HI/LO register pair and shares it between the multicycle multiplier and the multicycle divider.
- Decodes the EX-stage mul/div/MTHI/MTLO operation and issues a one-cycle start pulse to the selected unit.
- Holds that unit's operands and sign mode stable until its ready pulse, then commits the 64-bit result to HI/LO.
- Drives the pipeline stall and abandons in-flight operations on flush so exceptions stay precise.

---
 rtl/muldiv_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and sequencer for the shared multicycle multiplier and divider.
// Issues start pulses, holds operands, commits results and handles flush/timeout.
module muldiv_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CNT_W       = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         op_i,
  input  logic [31:0]        a_i,
  input  logic [31:0]        b_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic [31:0]        hi_o,
  output logic [31:0]        lo_o,
  output logic               err_o,
  output logic               mul_start_o,
  output logic               mul_signed_o,
  output logic [31:0]        mul_a_o,
  output logic [31:0]        mul_b_o,
  input  logic               mul_ready_i,
  input  logic [63:0]        mul_result_i,
  output logic               div_start_o,
  output logic               div_signed_o,
  output logic [31:0]        div_a_o,
  output logic [31:0]        div_b_o,
  output logic               div_annul_o,
  input  logic               div_ready_i,
  input  logic [63:0]        div_result_i
);

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_BUSY, S_DIV_BUSY, S_DONE, S_DRAIN, S_COOL
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic              err_q, err_d;
  logic              mul_start_q, mul_start_d, mul_signed_q, mul_signed_d;
  logic [XLEN-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic              div_start_q, div_start_d, div_signed_q, div_signed_d;
  logic [XLEN-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic              div_annul_q, div_annul_d;
  logic [2*XLEN-1:0] res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              unit_div_q, unit_div_d;

  logic is_mul_c, is_div_c, div_ok_c, op_valid_c, ready_c, timeout_c, drain_to_c;

  assign is_mul_c   = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div_c   = (op_i == OP_DIV) || (op_i == OP_DIVU);
  assign div_ok_c   = (b_i != '0);
  assign op_valid_c = (op_i != 3'd0) && (op_i != 3'd7);
  assign timeout_c  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign drain_to_c = (cnt_q >= CNT_W'(TIMEOUT_CYC - 1));

  // Next-state, HI/LO writes, issue and stall decode
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    err_d        = err_q;
    mul_start_d  = 1'b0;
    mul_signed_d = mul_signed_q;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    div_start_d  = 1'b0;
    div_signed_d = div_signed_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    div_annul_d  = 1'b0;
    res_d        = res_q;
    cnt_d        = cnt_q;
    unit_div_d   = unit_div_q;
    ready_c      = 1'b0;
    stall_o      = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_o = (is_mul_c || (is_div_c && div_ok_c)) && !flush_i;
        if (!flush_i) begin
          if (is_mul_c) begin
            mul_start_d  = 1'b1;
            mul_signed_d = (op_i == OP_MULT);
            mul_a_d      = a_i;
            mul_b_d      = b_i;
            cnt_d        = '0;
            unit_div_d   = 1'b0;
            state_d      = S_MUL_BUSY;
          end else if (is_div_c && div_ok_c) begin
            div_start_d  = 1'b1;
            div_signed_d = (op_i == OP_DIV);
            div_a_d      = a_i;
            div_b_d      = b_i;
            cnt_d        = '0;
            unit_div_d   = 1'b1;
            state_d      = S_DIV_BUSY;
          end else if (op_i == OP_MTHI) begin
            hi_d = a_i;
          end else if (op_i == OP_MTLO) begin
            lo_d = a_i;
          end
        end
      end
      S_MUL_BUSY, S_DIV_BUSY: begin
        stall_o = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        ready_c = (state_q == S_MUL_BUSY) ? mul_ready_i : div_ready_i;
        // A flush beats a same-cycle ready; a finished unit needs no drain
        if (flush_i) begin
          if (ready_c) begin
            state_d = S_COOL;
          end else begin
            div_annul_d = unit_div_q;
            state_d     = S_DRAIN;
          end
        end else if (ready_c) begin
          res_d   = unit_div_q ? div_result_i : mul_result_i;
          state_d = S_DONE;
        end else if (timeout_c) begin
          err_d       = 1'b1;
          div_annul_d = unit_div_q;
          state_d     = S_DRAIN;
        end
      end
      S_DONE: begin
        if (!flush_i) begin
          hi_d = res_q[2*XLEN-1:XLEN];
          lo_d = res_q[XLEN-1:0];
        end
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        stall_o = op_valid_c && !flush_i;
        cnt_d   = cnt_q + CNT_W'(1);
        // Divider is idle once the annul pulse has been seen; multiplier must finish
        if (unit_div_q ? !div_annul_q : mul_ready_i) begin
          state_d = S_COOL;
        end else if (drain_to_c) begin
          err_d   = 1'b1;
          state_d = S_COOL;
        end
      end
      S_COOL: begin
        stall_o = op_valid_c && !flush_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      hi_q         <= '0;
      lo_q         <= '0;
      err_q        <= 1'b0;
      mul_start_q  <= 1'b0;
      mul_signed_q <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      div_start_q  <= 1'b0;
      div_signed_q <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_annul_q  <= 1'b0;
      res_q        <= '0;
      cnt_q        <= '0;
      unit_div_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      err_q        <= err_d;
      mul_start_q  <= mul_start_d;
      mul_signed_q <= mul_signed_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      div_start_q  <= div_start_d;
      div_signed_q <= div_signed_d;
      div_a_q      <= div_a_d;
      div_b_q      <= div_b_d;
      div_annul_q  <= div_annul_d;
      res_q        <= res_d;
      cnt_q        <= cnt_d;
      unit_div_q   <= unit_div_d;
    end
  end

  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign err_o        = err_q;
  assign mul_start_o  = mul_start_q;
  assign mul_signed_o = mul_signed_q;
  assign mul_a_o      = mul_a_q;
  assign mul_b_o      = mul_b_q;
  assign div_start_o  = div_start_q;
  assign div_signed_o = div_signed_q;
  assign div_a_o      = div_a_q;
  assign div_b_o      = div_b_q;
  assign div_annul_o  = div_annul_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus flush, timeout and reset sequences.
module tb_muldiv_ctrl;

  logic        clk, rst;
  logic [2:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        stall_o, err_o;
  logic [31:0] hi_o, lo_o;
  logic        mul_start_o, mul_signed_o, mul_ready_i;
  logic [31:0] mul_a_o, mul_b_o;
  logic [63:0] mul_result_i;
  logic        div_start_o, div_signed_o, div_annul_o, div_ready_i;
  logic [31:0] div_a_o, div_b_o;
  logic [63:0] div_result_i;

  int n_chk  = 0;
  int n_fail = 0;

  muldiv_ctrl #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .op_i(op_i), .a_i(a_i), .b_i(b_i), .flush_i(flush_i),
    .stall_o(stall_o), .hi_o(hi_o), .lo_o(lo_o), .err_o(err_o),
    .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o), .div_annul_o(div_annul_o),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [63:0] res;
    logic        issue;
    logic        sgn;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int   stalls, starts, others, busy;
    logic held, done, is_mul;
    is_mul  = (v.op == 3'd1) || (v.op == 3'd2);
    op_i    = v.op;
    a_i     = v.a;
    b_i     = v.b;
    flush_i = 1'b0;
    #1 chk({tag, "_stall_issue"}, 64'(stall_o), 64'(v.issue));
    if (v.issue) begin
      stalls = 1; starts = 0; others = 0; busy = 0; held = 1'b1; done = 1'b0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge clk);
        mul_ready_i = 1'b0;
        div_ready_i = 1'b0;
        busy++;
        if (is_mul) begin
          if (mul_start_o) starts++;
          if (div_start_o) others++;
          if (mul_a_o !== v.a || mul_b_o !== v.b || mul_signed_o !== v.sgn) held = 1'b0;
        end else begin
          if (div_start_o) starts++;
          if (mul_start_o) others++;
          if (div_a_o !== v.a || div_b_o !== v.b || div_signed_o !== v.sgn) held = 1'b0;
        end
        if (busy == v.lat) begin
          if (is_mul) begin mul_ready_i = 1'b1; mul_result_i = v.res; end
          else        begin div_ready_i = 1'b1; div_result_i = v.res; end
        end
        // The other unit's ready must be ignored
        if (busy == 2 && v.lat > 2) begin
          if (is_mul) begin div_ready_i = 1'b1; div_result_i = ~v.res; end
          else        begin mul_ready_i = 1'b1; mul_result_i = ~v.res; end
        end
        #1;
        if (stall_o) stalls++;
        else done = 1'b1;
      end
      chk({tag, "_done_reached"}, 64'(done), 64'(1));
      chk({tag, "_stall_cycles"}, 64'(stalls), 64'(1 + v.lat));
      chk({tag, "_start_pulses"}, 64'(starts), 64'(1));
      chk({tag, "_other_starts"}, 64'(others), 64'(0));
      chk({tag, "_operands_held"}, 64'(held), 64'(1));
    end
    @(negedge clk);
    mul_ready_i = 1'b0;
    div_ready_i = 1'b0;
    op_i        = 3'd0;
    chk({tag, "_hi"}, 64'(hi_o), 64'(v.hi));
    chk({tag, "_lo"}, 64'(lo_o), 64'(v.lo));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hilo"}, {hi_o, lo_o}, 64'd0);
    chk({tag, "_flags"}, 64'({err_o, stall_o, mul_start_o, mul_signed_o,
                              div_start_o, div_signed_o, div_annul_o}), 64'd0);
    chk({tag, "_mul_ops"}, {mul_a_o, mul_b_o}, 64'd0);
    chk({tag, "_div_ops"}, {div_a_o, div_b_o}, 64'd0);
  endtask

  initial begin
    int   k, annul;
    logic stall_ok;

    //            op    a             b             lat res                     iss sgn hi            lo
    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,       5,  64'hFFFFFFFF_FFFFFFFA, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'd4, 32'd7,        32'd2,       33, 64'h00000001_00000003, 1, 0, 32'd1,        32'd3};
    vecs[2] = '{3'd2, 32'h00010000, 32'h00010000, 4, 64'h00000001_00000000, 1, 0, 32'd1,        32'd0};
    vecs[3] = '{3'd3, 32'hFFFFFFF9, 32'd2,       10, 64'hFFFFFFFF_FFFFFFFD, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{3'd3, 32'd5,        32'd0,       0,  64'd0,                 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5] = '{3'd6, 32'h00001234, 32'd0,       0,  64'd0,                 0, 0, 32'hFFFFFFFF, 32'h00001234};
    vecs[6] = '{3'd5, 32'h0000ABCD, 32'd0,       0,  64'd0,                 0, 0, 32'h0000ABCD, 32'h00001234};

    rst = 1'b1; op_i = 3'd0; a_i = '0; b_i = '0; flush_i = 1'b0;
    mul_ready_i = 1'b0; mul_result_i = '0; div_ready_i = 1'b0; div_result_i = '0;
    #3 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Flush mid-divide; a MULT waits through DRAIN/COOL and issues from IDLE
    op_i = 3'd3; a_i = 32'd100; b_i = 32'd7;
    for (int i = 0; i < 10; i++) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; op_i = 3'd1; a_i = 32'd3; b_i = 32'd4;
    k = 0; annul = 0; stall_ok = 1'b1;
    while (k < 20) begin
      k++;
      #1;
      if (mul_start_o) break;
      if (div_annul_o) annul++;
      if (!stall_o) stall_ok = 1'b0;
      @(negedge clk);
    end
    chk("flush_issue_delay", 64'(k), 64'd5);
    chk("flush_annul_pulses", 64'(annul), 64'd1);
    chk("flush_mult_stalled", 64'(stall_ok), 64'd1);
    chk("flush_hilo_kept", {hi_o, lo_o}, {32'h0000ABCD, 32'h00001234});
    @(negedge clk);
    @(negedge clk);
    mul_ready_i = 1'b1; mul_result_i = 64'd12;
    @(negedge clk);
    mul_ready_i = 1'b0;
    #1 chk("flush_mult_done_stall", 64'(stall_o), 64'd0);
    @(negedge clk);
    op_i = 3'd0;
    chk("flush_mult_hilo", {hi_o, lo_o}, {32'd0, 32'd12});

    // Ready and flush together: result dropped, COOL stalls an MTHI for one cycle
    op_i = 3'd1; a_i = 32'd5; b_i = 32'd6;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mul_ready_i = 1'b1; mul_result_i = 64'd30; flush_i = 1'b1;
    @(negedge clk);
    mul_ready_i = 1'b0; flush_i = 1'b0; op_i = 3'd5; a_i = 32'h5555;
    #1 chk("race_cool_stall", 64'(stall_o), 64'd1);
    @(negedge clk);
    #1 chk("race_idle_stall", 64'(stall_o), 64'd0);
    chk("race_hilo_kept", {hi_o, lo_o}, {32'd0, 32'd12});
    @(negedge clk);
    op_i = 3'd0;
    chk("race_mthi", 64'(hi_o), 64'h5555);

    // Multiplier never answers: sticky timeout
    op_i = 3'd1; a_i = 32'd1; b_i = 32'd1;
    chk("to_err_before", 64'(err_o), 64'd0);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      k++;
      #1;
      if (err_o) break;
    end
    op_i = 3'd0;
    chk("to_err_cycle", 64'(k), 64'd65);
    for (int i = 0; i < 3; i++) @(negedge clk);
    #1;
    chk("to_hilo_kept", {hi_o, lo_o}, {32'h5555, 32'd12});
    chk("to_err_sticky", 64'(err_o), 64'd1);
    chk("to_idle_stall", 64'(stall_o), 64'd0);

    // Asynchronous reset mid-divide
    op_i = 3'd3; a_i = 32'd9; b_i = 32'd3;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("rst_pre_div_a", 64'(div_a_o), 64'd9);
    op_i = 3'd0;
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
